// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch front end.
// Owns the program counter and issues at most one outstanding fetch on the
// instruction bus. Returned words go to the if_id register, or to a one-entry
// buffer while the decode side is held. Redirects from pipeline control
// abandon or discard the in-flight fetch.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   jump_flag_i     redirect request; jump_addr_i is the new pc
//   hold_flag_i     ordered hold level: 0 none, 1 pc, 2 if, 3 id
//   ibus_req_o      fetch request valid; ibus_addr_o is the fetch address
//   ibus_ack_i      request accepted this cycle
//   ibus_rvalid_i   read data valid; ibus_rdata_i is the data
//   inst_o          instruction to if_id, with inst_addr_o and inst_valid_o
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding; may issue a fetch from pc
// REQ   | ibus_req_o high, waiting for ibus_ack_i
// WAIT  | request accepted, waiting for data to deliver
// DROP  | request accepted after a redirect, data will be discarded
module pc_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [2:0] HOLD_PC = 3'd1;
    localparam logic [2:0] HOLD_IF = 3'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        inst_valid_q, inst_valid_d;

    logic hold_pc;
    logic hold_if;
    logic acked;
    logic rsp_wait;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        drop_d       = drop_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        buf_addr_d   = buf_addr_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;

        hold_pc  = (hold_flag_i >= HOLD_PC);
        hold_if  = (hold_flag_i >= HOLD_IF);
        acked    = (state_q == S_REQ) && ibus_ack_i;
        // Data only counts while a live fetch is waiting for it; stray
        // rvalid in any other state is ignored.
        rsp_wait = (state_q == S_WAIT) && ibus_rvalid_i;

        case (state_q)
            S_IDLE: begin
                // A jump empties the buffer this cycle, so it does not block.
                if (!hold_pc && (jump_flag_i || !buf_valid_q)) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = jump_flag_i ? jump_addr_i : pc_q;
                end
            end
            S_REQ: begin
                if (jump_flag_i) begin
                    drop_d = 1'b1;
                end
                if (acked) begin
                    req_d   = 1'b0;
                    state_d = (drop_q || jump_flag_i) ? S_DROP : S_WAIT;
                    // After a redirect pc already holds the target; the
                    // abandoned fetch must not advance it.
                    if (!drop_q) begin
                        pc_d = addr_q + 32'd4;
                    end
                end
            end
            S_WAIT: begin
                // Jump together with data consumes the response, so there is
                // nothing left to drop.
                if (ibus_rvalid_i) begin
                    state_d = S_IDLE;
                end else if (jump_flag_i) begin
                    state_d = S_DROP;
                end
            end
            default: begin
                if (ibus_rvalid_i) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                end
            end
        endcase

        if (jump_flag_i) begin
            pc_d = jump_addr_i;
        end

        if (jump_flag_i) begin
            buf_valid_d  = 1'b0;
            inst_d       = NOP_INST;
            inst_addr_d  = jump_addr_i;
            inst_valid_d = 1'b0;
        end else if (hold_if) begin
            if (rsp_wait) begin
                buf_valid_d = 1'b1;
                buf_data_d  = ibus_rdata_i;
                buf_addr_d  = addr_q;
            end
        end else if (buf_valid_q) begin
            // A full buffer blocks new requests, so no data can collide here.
            inst_d       = buf_data_q;
            inst_addr_d  = buf_addr_q;
            inst_valid_d = 1'b1;
            buf_valid_d  = 1'b0;
        end else if (rsp_wait) begin
            inst_d       = ibus_rdata_i;
            inst_addr_d  = addr_q;
            inst_valid_d = 1'b1;
        end else begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_ADDR;
            req_q        <= 1'b0;
            addr_q       <= RESET_ADDR;
            drop_q       <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_data_q   <= NOP_INST;
            buf_addr_q   <= RESET_ADDR;
            inst_q       <= NOP_INST;
            inst_addr_q  <= RESET_ADDR;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            drop_q       <= drop_d;
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            buf_addr_q   <= buf_addr_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign ibus_req_o   = req_q;
    assign ibus_addr_o  = addr_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized and directed stimulus for pc_fetch, checked every
// cycle against a transaction-level model (queue of accepted fetches, a
// one-entry buffer queue), plus literal checks on the directed scenarios.
module tb_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0001;
    localparam logic [31:0] RA  = 32'h0000_0000;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [2:0]  hold_flag_i = '0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_ack_i   (ibus_ack_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    bit          rand_en   = 1'b0;
    int          ack_pct   = 100;
    int          rv_dly    = 0;
    bit          dir_jump  = 1'b0;
    logic [31:0] dir_jaddr = '0;
    logic [2:0]  dir_hold  = '0;
    bit          dir_stray = 1'b0;

    // bus responder
    bit          bus_busy = 1'b0;
    int          bus_cnt  = 0;
    logic [31:0] bus_addr = '0;

    typedef struct { logic [31:0] a; logic [31:0] d; } out_t;
    logic [31:0] acc_log[$];
    out_t        out_log[$];

    // behavioural model
    typedef struct { logic [31:0] a; logic drop; } pend_t;
    pend_t       pend[$];
    out_t        bufq[$];
    logic        m_req = 1'b0;
    logic        m_req_drop = 1'b0;
    logic [31:0] m_addr = RA;
    logic [31:0] m_pc = RA;
    logic [31:0] m_inst = NOP;
    logic [31:0] m_iaddr = RA;
    logic        m_ivalid = 1'b0;

    task automatic model_step();
        pend_t e;
        logic  have, keep, acc, start_idle, buf_empty0;
        if (!rst) begin
            pend.delete(); bufq.delete();
            m_req = 0; m_req_drop = 0; m_addr = RA; m_pc = RA;
            m_inst = NOP; m_iaddr = RA; m_ivalid = 0;
            return;
        end
        start_idle = !m_req && (pend.size() == 0);
        buf_empty0 = (bufq.size() == 0);
        acc  = m_req && ibus_ack_i;
        have = ibus_rvalid_i && (pend.size() > 0);
        keep = 0;
        e.a = '0; e.drop = 0;
        if (have) begin
            e = pend.pop_front();
            keep = !e.drop && !jump_flag_i;
        end
        if (jump_flag_i) foreach (pend[i]) pend[i].drop = 1;
        if (jump_flag_i) m_pc = jump_addr_i;
        else if (acc && !m_req_drop) m_pc = m_addr + 32'd4;

        if (jump_flag_i) begin
            m_inst = NOP; m_ivalid = 0; m_iaddr = jump_addr_i; bufq.delete();
        end else if (hold_flag_i >= 3'd2) begin
            if (keep) bufq.push_back('{a: e.a, d: ibus_rdata_i});
        end else if (bufq.size() > 0) begin
            out_t b;
            b = bufq.pop_front();
            m_inst = b.d; m_iaddr = b.a; m_ivalid = 1;
        end else if (keep) begin
            m_inst = ibus_rdata_i; m_iaddr = e.a; m_ivalid = 1;
        end else begin
            m_inst = NOP; m_ivalid = 0;
        end

        if (acc) begin
            pend.push_back('{a: m_addr, drop: m_req_drop || jump_flag_i});
            m_req = 0; m_req_drop = 0;
        end else if (m_req) begin
            if (jump_flag_i) m_req_drop = 1;
        end else if (start_idle && hold_flag_i < 3'd1 && (jump_flag_i || buf_empty0)) begin
            m_req = 1; m_req_drop = 0; m_addr = m_pc;
        end
    endtask

    // cycle engine: drive at negedge, model at posedge, compare 1 after
    initial begin
        forever begin
            @(negedge clk);
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
            if (bus_busy) begin
                if (bus_cnt == 0) begin
                    ibus_rvalid_i = 1'b1;
                    ibus_rdata_i  = bus_addr ^ KEY;
                    bus_busy      = 1'b0;
                end else begin
                    bus_cnt--;
                end
            end else if (dir_stray) begin
                ibus_rvalid_i = 1'b1;
            end
            if (rand_en) begin
                jump_flag_i = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 3) == 0) jump_addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else jump_addr_i = $urandom & 32'h0000_0FFC;
                hold_flag_i = ($urandom_range(0, 99) < 70) ? 3'd0 : 3'($urandom_range(1, 4));
                ibus_ack_i  = ($urandom_range(0, 99) < 60);
            end else begin
                jump_flag_i = dir_jump;
                jump_addr_i = dir_jaddr;
                hold_flag_i = dir_hold;
                ibus_ack_i  = ($urandom_range(0, 99) < ack_pct);
            end
            if (rst && ibus_req_o && ibus_ack_i) begin
                acc_log.push_back(ibus_addr_o);
                bus_busy = 1'b1;
                bus_addr = ibus_addr_o;
                bus_cnt  = rand_en ? $urandom_range(0, 2) : rv_dly;
            end
            @(posedge clk);
            model_step();
            #1;
            checks++;
            if ({ibus_req_o, ibus_addr_o, inst_o, inst_addr_o, inst_valid_o} !==
                {m_req, m_addr, m_inst, m_iaddr, m_ivalid}) begin
                errors++;
                if (errors < 20)
                    $display("FAIL cycle_model t=%0t got req=%0b addr=%h inst=%h iaddr=%h v=%0b exp req=%0b addr=%h inst=%h iaddr=%h v=%0b",
                             $time, ibus_req_o, ibus_addr_o, inst_o, inst_addr_o, inst_valid_o,
                             m_req, m_addr, m_inst, m_iaddr, m_ivalid);
            end
            if (inst_valid_o) out_log.push_back('{a: inst_addr_o, d: inst_o});
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus_busy = 1'b0;
        run(2);
        rst = 1'b1;
    endtask

    task automatic wait_acc(int n, string nm);
        int k = 0;
        while (acc_log.size() < n && k < 100) begin
            run(1);
            k++;
        end
        chk(nm, 32'(acc_log.size()), 32'(n));
    endtask

    function automatic logic [31:0] acc_at(int i);
        if (i < acc_log.size()) return acc_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] out_a(int i);
        if (i < out_log.size()) return out_log[i].a;
        return 'x;
    endfunction

    function automatic logic [31:0] out_d(int i);
        if (i < out_log.size()) return out_log[i].d;
        return 'x;
    endfunction

    initial begin
        // reset values
        run(3);
        chk("rst_req", 32'(ibus_req_o), 32'd0);
        chk("rst_addr", ibus_addr_o, RA);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, RA);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);

        // straight-line fetch 0,4,8
        ack_pct = 100; rv_dly = 0;
        acc_log.delete(); out_log.delete();
        rst = 1'b1;
        run(12);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("seq_acc%0d", i), acc_at(i), 32'(4 * i));
            chk($sformatf("seq_oaddr%0d", i), out_a(i), 32'(4 * i));
            chk($sformatf("seq_odata%0d", i), out_d(i), 32'(4 * i) ^ KEY);
        end

        // reset while waiting, data returns during reset
        acc_log.delete();
        wait_acc(1, "rstwait_timeout");
        rst = 1'b0;
        run(2);
        chk("rstwait_valid", 32'(inst_valid_o), 32'd0);
        chk("rstwait_inst", inst_o, NOP);
        chk("rstwait_req", 32'(ibus_req_o), 32'd0);
        acc_log.delete(); out_log.delete();
        rst = 1'b1;
        run(12);
        chk("rstwait_acc0", acc_at(0), RA);
        chk("rstwait_out0", out_a(0), RA);
        chk("rstwait_dat0", out_d(0), RA ^ KEY);

        // jump while waiting for 0x8
        rv_dly = 2;
        acc_log.delete();
        do_reset();
        wait_acc(3, "jwait_timeout");
        chk("jwait_acc2", acc_at(2), 32'h8);
        out_log.delete();
        dir_jump = 1'b1; dir_jaddr = 32'h100;
        run(1);
        dir_jump = 1'b0;
        chk("jwait_valid", 32'(inst_valid_o), 32'd0);
        run(20);
        chk("jwait_acc3", acc_at(3), 32'h100);
        chk("jwait_out0", out_a(0), 32'h100);
        chk("jwait_dat0", out_d(0), 32'h100 ^ KEY);

        // jump while request is pending, ack held off
        rv_dly = 0; ack_pct = 0;
        acc_log.delete();
        do_reset();
        run(1);
        chk("jreq_req", 32'(ibus_req_o), 32'd1);
        dir_jump = 1'b1; dir_jaddr = 32'h200;
        run(1);
        dir_jump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("jreq_hold_addr%0d", i), ibus_addr_o, RA);
            chk($sformatf("jreq_hold_req%0d", i), 32'(ibus_req_o), 32'd1);
            run(1);
        end
        ack_pct = 100;
        out_log.delete();
        run(12);
        chk("jreq_acc0", acc_at(0), RA);
        chk("jreq_acc1", acc_at(1), 32'h200);
        chk("jreq_out0", out_a(0), 32'h200);

        // Hold_If spanning the return of 0xC
        rv_dly = 1;
        acc_log.delete();
        do_reset();
        wait_acc(4, "hif_timeout");
        chk("hif_acc3", acc_at(3), 32'hC);
        dir_hold = 3'd2;
        for (int i = 0; i < 4; i++) begin
            run(1);
            chk($sformatf("hif_iaddr%0d", i), inst_addr_o, 32'h8);
            chk($sformatf("hif_valid%0d", i), 32'(inst_valid_o), 32'd0);
            chk($sformatf("hif_req%0d", i), 32'(ibus_req_o), 32'd0);
        end
        dir_hold = 3'd0;
        acc_log.delete();
        run(1);
        chk("hif_rel_valid", 32'(inst_valid_o), 32'd1);
        chk("hif_rel_iaddr", inst_addr_o, 32'hC);
        chk("hif_rel_inst", inst_o, 32'hC ^ KEY);
        run(8);
        chk("hif_next_acc", acc_at(0), 32'h10);

        // Hold_Pc in IDLE, stray rvalid, wrap from 0xFFFF_FFFC
        rv_dly = 0;
        dir_hold = 3'd1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run(1);
            chk($sformatf("hpc_req%0d", i), 32'(ibus_req_o), 32'd0);
            chk($sformatf("hpc_inst%0d", i), inst_o, NOP);
        end
        dir_stray = 1'b1;
        run(1);
        dir_stray = 1'b0;
        chk("stray_valid", 32'(inst_valid_o), 32'd0);
        dir_jump = 1'b1; dir_jaddr = 32'hFFFF_FFFC;
        run(1);
        dir_jump = 1'b0;
        chk("hpc_jump_req", 32'(ibus_req_o), 32'd0);
        chk("hpc_jump_iaddr", inst_addr_o, 32'hFFFF_FFFC);
        dir_hold = 3'd0;
        acc_log.delete();
        run(10);
        chk("wrap_acc0", acc_at(0), 32'hFFFF_FFFC);
        chk("wrap_acc1", acc_at(1), 32'h0);

        // randomized traffic with one mid-run reset
        rand_en = 1'b1;
        run(1500);
        do_reset();
        run(1500);
        rand_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
